iter_mul_ctrl: RTL and testbench

- Iterative shift-add multiply sequencer for the RV32M MUL/MULH/MULHSU/MULHU ops in the execute stage.
- Time-shares one XLEN+1-bit add step across XLEN cycles instead of a full array multiplier.
- Takes one request at a time over a valid/ready handshake and returns the selected product half over a valid/ready handshake.

---
 rtl/iter_mul_pkg.sv | 28 ++
 rtl/mul_add_step.sv | 20 ++
 rtl/iter_mul_ctrl.sv | 152 +++++++++++++++
 tb/tb_iter_mul_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/iter_mul_pkg.sv
// Shared encodings and helpers for the iterative RV32M multiply sequencer.
package iter_mul_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // rs1 is signed for every op except MULHU
    function automatic logic op_a_signed(input logic [1:0] op);
        return op != OP_MULHU;
    endfunction

    // rs2 is signed only for MUL and MULH
    function automatic logic op_b_signed(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_add_step.sv
// One shift-add step: conditional add of mcand into acc, then shift {sum,mplier} right by one.
module mul_add_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] mplier,
    input  logic [XLEN-1:0] mcand,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] mplier_nxt
);

    logic [XLEN:0] sum;

    always_comb begin
        sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : (XLEN+1)'(0));
        acc_nxt    = sum[XLEN:1];
        mplier_nxt = {sum[0], mplier[XLEN-1:1]};
    end

endmodule

// File: rtl/iter_mul_ctrl.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU with valid/ready request and response.
// Define ITER_MUL_EARLY_TERM_EN to finish BUSY early once the remaining multiplier bits are zero.
module iter_mul_ctrl
    import iter_mul_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [1:0]      op_sel,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              neg_q, neg_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0]   acc_step, mplier_step;
    logic              sign_a, sign_b;
    logic [PW-1:0]     prod_neg;

`ifdef ITER_MUL_EARLY_TERM_EN
    logic [CNT_W:0]    used_bits;
    logic [XLEN-1:0]   rem_bits;
`endif

    mul_add_step #(.XLEN(XLEN)) u_step (
        .acc        (acc_q),
        .mplier     (mplier_q),
        .mcand      (mcand_q),
        .acc_nxt    (acc_step),
        .mplier_nxt (mplier_step)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            acc_q        <= '0;
            mplier_q     <= '0;
            mcand_q      <= '0;
            neg_q        <= 1'b0;
            op_q         <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            acc_q        <= acc_d;
            mplier_q     <= mplier_d;
            mcand_q      <= mcand_d;
            neg_q        <= neg_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state, datapath and handshake outputs
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        acc_d        = acc_q;
        mplier_d     = mplier_q;
        mcand_d      = mcand_q;
        neg_d        = neg_q;
        op_d         = op_q;
        cnt_d        = cnt_q;

        sign_a   = op_a_signed(op_sel) & op_a[XLEN-1];
        sign_b   = op_b_signed(op_sel) & op_b[XLEN-1];
        prod_neg = ~{acc_q, mplier_q} + PW'(1);

`ifdef ITER_MUL_EARLY_TERM_EN
        // Unshifted multiplier bits above the one consumed this cycle
        used_bits = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
        rem_bits  = (mplier_q >> 1) << used_bits;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    mcand_d     = sign_a ? (~op_a + XLEN'(1)) : op_a;
                    mplier_d    = sign_b ? (~op_b + XLEN'(1)) : op_b;
                    neg_d       = sign_a ^ sign_b;
                    op_d        = op_sel;
                    acc_d       = '0;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_step;
                mplier_d = mplier_step;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = FIX;
                end
`ifdef ITER_MUL_EARLY_TERM_EN
                else if (rem_bits == '0) begin
                    {acc_d, mplier_d} = {acc_step, mplier_step} >> (CNT_W'(XLEN - 1) - cnt_q);
                    state_d           = FIX;
                end
`endif
            end
            FIX: begin
                if (neg_q) begin
                    {acc_d, mplier_d} = prod_neg;
                end
                state_d = DONE;
            end
            DONE: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                    result_d     = (op_q == OP_MUL) ? mplier_q : acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign result     = result_q;

endmodule

// File: tb/tb_iter_mul_ctrl.sv
// Randomized and directed bench for iter_mul_ctrl against a 64-bit arithmetic reference.
module tb_iter_mul_ctrl;
    import iter_mul_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [1:0]      op_sel;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

    iter_mul_ctrl #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sel     (op_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Full 64-bit product with operands extended per instruction signedness
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = (op != 2'd3) ? longint'($signed(a)) : longint'(a);
        sb = (op == 2'd0 || op == 2'd1) ? longint'($signed(b)) : longint'(b);
        p  = 64'(sa * sb);
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef ITER_MUL_EARLY_TERM_EN
        logic [31:0] m;
        int          h;
        m = ((op == 2'd0 || op == 2'd1) && b[31]) ? (32'd0 - b) : b;
        h = -1;
        for (int i = 0; i < 32; i++) if (m[i]) h = i;
        return ((h + 1) < 1 ? 1 : h + 1) + 2;
`else
        return (op == 2'd3 && b == 32'hDEADBEEF) ? 34 : 34;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = corners[$urandom_range(0, 5)];
            2:       v = 32'($urandom_range(0, 15));
            default: v = 32'($urandom) >> $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit pulse);
        int          lat;
        bit          rdy_bad;
        logic [31:0] exp_r;
        exp_r = ref_mul(op, a, b);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        op_sel    = op;
        op_a      = a;
        op_b      = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        op_sel    = 2'($urandom);
        lat       = 0;
        rdy_bad   = 1'b0;
        while (!resp_valid && lat < 200) begin
            if (req_ready) rdy_bad = 1'b1;
            req_valid = (pulse && lat == 5);
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat(op, b)));
        check("req_ready_busy", 64'(rdy_bad), 64'd0);
        check("result", 64'(result), 64'(exp_r));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_result", 64'(result), 64'(exp_r));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_valid_clear", 64'(resp_valid), 64'd0);
        if (pulse) begin
            repeat (3) @(posedge clk);
            #1;
            check("no_ghost_resp", 64'(resp_valid), 64'd0);
            check("ready_after_pulse", 64'(req_ready), 64'd1);
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        op_a       = '0;
        op_b       = '0;
        op_sel     = '0;
        #23;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(OP_MUL,    32'd7,        32'd6,        0, 1'b0);
        run_op(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        run_op(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        run_op(OP_MULH,   32'h80000000, 32'h80000000, 0, 1'b0);
        run_op(OP_MULH,   32'h80000000, 32'h00000001, 0, 1'b0);
        run_op(OP_MULHU,  32'd7,        32'd6,        0, 1'b0);
        run_op(OP_MUL,    32'h12345678, 32'h0,        0, 1'b0);
        run_op(OP_MULHU,  32'h9ABCDEF0, 32'h80000000, 0, 1'b0);
        run_op(OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 5, 1'b0);
        run_op(OP_MUL,    32'hDEADBEEF, 32'hC0FFEE11, 0, 1'b1);

        // Reset in the middle of BUSY aborts the operation
        req_valid = 1'b1;
        op_sel    = OP_MUL;
        op_a      = 32'h0BADF00D;
        op_b      = 32'h76543210;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_resp_valid", 64'(resp_valid), 64'd0);
        run_op(OP_MULH, 32'hFFFFFFF9, 32'd6, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, $urandom_range(0, 2), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
